// File: rtl/i2c_tgt_pkg.sv
// rtl/i2c_tgt_pkg.sv - shared state encoding and SSD1306 constants for the I2C OLED target
package i2c_tgt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_DATA,
    ST_IGNORE
  } tgt_state_e;

  localparam int         CTRL_CO_BIT      = 7;
  localparam int         CTRL_DC_BIT      = 6;
  localparam logic [6:0] DEV_ID_DEFAULT   = 7'h3C;

  // SSD1306 control bytes: single command, command stream, data stream
  localparam logic [7:0] CTRL_CMD_SINGLE  = 8'h80;
  localparam logic [7:0] CTRL_CMD_STREAM  = 8'h00;
  localparam logic [7:0] CTRL_DATA_STREAM = 8'h40;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchroniser, deglitch counter and edge pulses for one I2C line
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Level flips only after FILT_LEN consecutive samples disagree with it
  always_comb begin
    sync_d  = {sync_q[0], i_line};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Registers reset to the idle (released, high) bus level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/i2c_oled_target.sv
// rtl/i2c_oled_target.sv - write-only I2C target decoding the SSD1306 byte stream; I2C_TGT_STRETCH_EN adds iReady clock stretching
module i2c_oled_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ID   = DEV_ID_DEFAULT,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ioScl,
  inout  wire        ioSda,
`ifdef I2C_TGT_STRETCH_EN
  input  logic       iReady,
`endif
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic       oValid,
  output logic       oFrameStart,
  output logic       oFrameEnd,
  output logic       oBusy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .i_line(ioScl),
    .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .i_line(ioSda),
    .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  tgt_state_e state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       co_q, co_d, dc_q, dc_d;
  logic       sda_drive_q, sda_drive_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_q, byte_d;
  logic       is_data_q, is_data_d;
  logic       valid_q, valid_d;
  logic       fstart_q, fstart_d;
  logic       fend_q, fend_d;
  logic       start_det, stop_det;
  logic [7:0] byte_done;

  // An SCL edge in the same clk as an SDA edge makes the SDA edge a data-bit event
  assign start_det = sda_fall & scl_lvl & ~scl_rise;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise;
  assign byte_done = {shift_q, sda_lvl};

`ifdef I2C_TGT_STRETCH_EN
  logic scl_hold_q, scl_hold_d;
`endif

  // Next-state: START/STOP take priority, then bit sampling and ACK slot handling
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    co_d        = co_q;
    dc_d        = dc_q;
    sda_drive_d = sda_drive_q;
    busy_d      = busy_q;
    byte_d      = byte_q;
    is_data_d   = is_data_q;
    valid_d     = 1'b0;
    fstart_d    = 1'b0;
    fend_d      = 1'b0;
`ifdef I2C_TGT_STRETCH_EN
    scl_hold_d  = scl_hold_q & ~iReady;
`endif
    if (stop_det) begin
      state_d     = ST_IDLE;
      shift_d     = '0;
      bit_cnt_d   = '0;
      sda_drive_d = 1'b0;
      busy_d      = 1'b0;
      fend_d      = busy_q;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      shift_d     = '0;
      bit_cnt_d   = '0;
      sda_drive_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (scl_rise && bit_cnt_q < 4'd8 && (state_q inside {ST_ADDR, ST_CTRL, ST_DATA})) begin
        shift_d   = byte_done[6:0];
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          case (state_q)
            ST_ADDR: begin
              if (byte_done[7:1] == DEV_ID && !byte_done[0]) begin
                state_d  = ST_ADDR_ACK;
                fstart_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
              end
            end
            ST_CTRL: begin
              co_d    = byte_done[CTRL_CO_BIT];
              dc_d    = byte_done[CTRL_DC_BIT];
              state_d = ST_CTRL_ACK;
            end
            default: begin
              byte_d    = byte_done;
              is_data_d = dc_q;
              valid_d   = 1'b1;
            end
          endcase
        end
      end
      // First fall after bit 7 drives ACK, the next one ends the slot
      if (scl_fall && bit_cnt_q == 4'd8 && (state_q inside {ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA})) begin
        if (!sda_drive_q) begin
          sda_drive_d = 1'b1;
        end else begin
          sda_drive_d = 1'b0;
          bit_cnt_d   = '0;
          case (state_q)
            ST_ADDR_ACK: state_d = ST_CTRL;
            ST_CTRL_ACK: state_d = ST_DATA;
            default: begin
              state_d = co_q ? ST_CTRL : ST_DATA;
`ifdef I2C_TGT_STRETCH_EN
              scl_hold_d = ~iReady;
`endif
            end
          endcase
        end
      end
    end
  end

  // State and output registers; reset releases SDA without waiting for a clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      co_q        <= 1'b0;
      dc_q        <= 1'b0;
      sda_drive_q <= 1'b0;
      busy_q      <= 1'b0;
      byte_q      <= '0;
      is_data_q   <= 1'b0;
      valid_q     <= 1'b0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      co_q        <= co_d;
      dc_q        <= dc_d;
      sda_drive_q <= sda_drive_d;
      busy_q      <= busy_d;
      byte_q      <= byte_d;
      is_data_q   <= is_data_d;
      valid_q     <= valid_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  // SCL hold register for clock stretching after a DATA ACK slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scl_hold_q <= 1'b0;
    else     scl_hold_q <= scl_hold_d;
  end
  assign ioScl = scl_hold_q ? 1'b0 : 1'bz;
`else
  assign ioScl = 1'bz;
`endif

  assign ioSda       = sda_drive_q ? 1'b0 : 1'bz;
  assign oByte       = byte_q;
  assign oIsData     = is_data_q;
  assign oValid      = valid_q;
  assign oFrameStart = fstart_q;
  assign oFrameEnd   = fend_q;
  assign oBusy       = busy_q;

endmodule
